sym_generator: RTL and testbench
================================

Name: sym_generator

Overview:
- Downstream consumer of the level controller's `newLevel` and `symGenMax` outputs.
- Divides `Clk100M` by the level-dependent period and presents one pseudo-random symbol per period to the player-input/scoring logic.
- Handshakes each symbol with its consumer and counts symbols that expire untaken.
- Raises `gameOver` after too many misses.

Parameters:
- SYM_W, 2: symbol width; symbols are 0..2^SYM_W-1.
- LFSR_SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- MAX_MISSES, 3: number of expired symbols that triggers `gameOver`. Legal range 1..15.
- MIN_PERIOD, 1000: floor applied to the latched period, in clock cycles.

Ports:
- Clk100M  input  1  system clock, 100 MHz.
- Rst  input  1  synchronous, active-high reset.
- newLevel  input  1  one-cycle pulse; (re)start generation at the new speed.
- symGenMax  input  32  symbol period in clock cycles; sampled only when `newLevel`=1.
- symTaken  input  1  consumer accepts the presented symbol.
- symValid  output  1  a symbol is presented and not yet taken.
- symOut  output  SYM_W  current symbol; meaningful only while `symValid`=1.
- symStrobe  output  1  one-cycle pulse on the cycle a new symbol first appears.
- missCount  output  4  number of expired symbols since reset.
- gameOver  output  1  sticky end-of-game flag.

Behaviour:
- Clock and reset: single clock `Clk100M`. Reset `Rst` is synchronous and active-high.
- Reset values:
  - Outputs: `symValid`=0, `symOut`=0, `symStrobe`=0, `missCount`=0, `gameOver`=0.
  - Internal: state=IDLE, cycle counter=0, period=MIN_PERIOD, LFSR=LFSR_SEED.
  - `Rst` overrides every other input in the same cycle.
- States: IDLE, RUN, OVER.
- IDLE:
  - Outputs are held at their reset values.
  - `newLevel`=1 → latch period, clear the counter, go to RUN.
- Period latch: period = max(symGenMax, MIN_PERIOD), computed with a 32-bit unsigned compare. A value of 0 is therefore clamped.
- RUN counter:
  - The counter increments every cycle.
  - At counter == period-1 (terminal), the counter wraps to 0 and a symbol event occurs.
  - First symbol appears `period` cycles after the `newLevel` cycle.
- Symbol event (terminal cycle), with the following cycle's outputs:
  - LFSR steps once.
  - `symOut` = new LFSR[SYM_W-1:0].
  - `symValid`=1, `symStrobe`=1 for exactly one cycle.
- Miss:
  - A miss occurs if `symValid`=1 and `symTaken`=0 on the terminal cycle.
  - On a miss, `missCount` increments (saturating at 15) and the old symbol is replaced.
  - If the incremented `missCount` reaches MAX_MISSES, go to OVER instead of presenting a new symbol.
- Take:
  - `symTaken`=1 while `symValid`=1 clears `symValid` on the next cycle. `symOut` is held.
  - `symTaken` while `symValid`=0 is ignored.
- Take and terminal in the same cycle: the take wins, no miss is counted, and the new symbol is presented on the next cycle.
- `newLevel` while in RUN:
  - Relatch the period and clear the counter.
  - A pending symbol stays valid; its expiry is measured against the new period.
  - `missCount` is retained and the LFSR does not step.
- `newLevel` coincident with the terminal cycle: `newLevel` wins; there is no symbol event and no miss check.
- OVER:
  - `gameOver`=1, `symValid`=0, `symStrobe`=0.
  - All inputs other than `Rst` are ignored. Only `Rst` exits.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). It steps only on symbol events.
- Latency: `symTaken` → `symValid` low takes 1 cycle. Terminal count → `symValid`/`symStrobe` high takes 1 cycle.

Decomposition:
- Shared package (e.g. sym_pkg):
  - state enum {IDLE, RUN, OVER}.
  - LFSR tap mask constant.
  - SYM_W default, shared with the scoring block.
- One natural sub-module: `lfsr16`, with ports clk, rst, step, seed → value.
- Counter, state machine and handshake stay in sym_generator.

Test Plan:
- Bench override: MIN_PERIOD=4.
- Reset, then `newLevel` with `symGenMax`=8:
  - `symStrobe` pulses exactly 8 cycles after `newLevel`.
  - `symOut` = LFSR_SEED stepped once, low 2 bits.
  - Subsequent strobes follow every 8 cycles.
- `symGenMax`=0 and then `symGenMax`=2 at `newLevel` → period clamps to 4; strobes every 4 cycles.
- Take each symbol 2 cycles after its strobe → `symValid` drops the following cycle; `missCount` stays 0 over 10 symbols.
- Never assert `symTaken`, period 8 → `missCount` goes 1, 2; at the third miss (cycle 32 after `newLevel`) `gameOver`=1 and `symValid`=0. Further `newLevel` pulses have no effect; `Rst` clears everything.
- `symTaken` on the same cycle as terminal → no miss, new symbol strobed next cycle.
- `newLevel` with `symGenMax`=16 at counter=5 while a symbol is pending:
  - Counter restarts and the next strobe comes 16 cycles later.
  - The pending symbol is then counted as one miss.
- Assert `Rst` mid-RUN with `symValid`=1 → all outputs 0 next cycle; state IDLE until `newLevel`.

Source files
------------

// File: rtl/sym_generator_pkg.sv
// Shared types and constants for the symbol generator and its consumers.
package sym_generator_pkg;

   // Default symbol width, also used by the scoring block.
   localparam int SYM_W_DEF = 2;

   // Galois LFSR feedback mask for x^16 + x^14 + x^13 + x^11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Default LFSR reset value.
   localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

   // Generator control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   // One right-shifting Galois step: feed the dropped LSB back through the tap mask.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/sym_generator_if.sv
// Symbol generator bus: level-controller inputs, consumer handshake and status.
//
// Handshake: symValid high means symOut holds a symbol not yet taken. The
// consumer takes it by raising symTaken for one cycle while symValid is high;
// symValid falls on the following cycle and symOut is held. symTaken while
// symValid is low has no effect. symStrobe marks the first cycle of each new
// symbol. state_dbg mirrors the generator FSM state for observation.
interface sym_generator_if
   import sym_generator_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF
) ();

   logic             newLevel;
   logic [31:0]      symGenMax;
   logic             symTaken;
   logic             symValid;
   logic [SYM_W-1:0] symOut;
   logic             symStrobe;
   logic [3:0]       missCount;
   logic             gameOver;
   state_t           state_dbg;

   // Level controller / consumer side.
   modport master (
      output newLevel, symGenMax, symTaken,
      input  symValid, symOut, symStrobe, missCount, gameOver, state_dbg
   );

   // Generator side.
   modport slave (
      input  newLevel, symGenMax, symTaken,
      output symValid, symOut, symStrobe, missCount, gameOver, state_dbg
   );

endinterface

// File: rtl/sym_generator_lfsr16.sv
// 16-bit Galois LFSR that advances one step only when asked to.
module lfsr16
   import sym_generator_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   // Advance on request, otherwise hold.
   always_comb begin
      value_d = value_q;
      if (step) begin
         value_d = lfsr_next(value_q);
      end
   end

   // Register with synchronous load of the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= seed;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/sym_generator.sv
// Level-paced pseudo-random symbol source with take handshake and miss counting.
module sym_generator
   import sym_generator_pkg::*;
#(
   parameter int          SYM_W      = SYM_W_DEF,
   parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF,
   parameter int          MAX_MISSES = 3,
   parameter int          MIN_PERIOD = 1000
) (
   input  logic            Clk100M,
   input  logic            Rst,
   sym_generator_if.slave  bus
);

   // A zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [31:0] MIN_P     = 32'(MIN_PERIOD);
   localparam logic [3:0]  MAX_MISS  = 4'(MAX_MISSES);

   state_t           state_q, state_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      period_q, period_d;
   logic             sym_valid_q, sym_valid_d;
   logic             sym_strobe_q, sym_strobe_d;
   logic [SYM_W-1:0] sym_out_q, sym_out_d;
   logic [3:0]       miss_q, miss_d;

   logic             lfsr_step;
   logic [15:0]      lfsr_val;
   logic [15:0]      lfsr_nxt;
   logic             lfsr_unused;

   logic             terminal;
   logic             take;
   logic             miss;
   logic [3:0]       miss_inc;
   logic [31:0]      period_new;

   lfsr16 u_lfsr (
      .clk   (Clk100M),
      .rst   (Rst),
      .step  (lfsr_step),
      .seed  (SEED_EFF),
      .value (lfsr_val)
   );

   // The symbol presented after an event is the LFSR value after its step.
   assign lfsr_nxt    = lfsr_next(lfsr_val);
   assign lfsr_unused = ^lfsr_nxt[15:SYM_W];

   assign terminal   = (cnt_q == (period_q - 32'd1));
   assign take       = bus.symTaken & sym_valid_q;
   assign miss       = sym_valid_q & ~bus.symTaken;
   assign miss_inc   = (miss_q == 4'hF) ? 4'hF : (miss_q + 4'd1);
   assign period_new = (bus.symGenMax < MIN_P) ? MIN_P : bus.symGenMax;

   // State register.
   always_ff @(posedge Clk100M) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: start on a level pulse, stop once the miss limit is reached.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.newLevel) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.newLevel && terminal && miss && (miss_inc >= MAX_MISS)) begin
               state_d = OVER;
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs and datapath: period counter, symbol events, take and miss handling.
   always_comb begin
      cnt_d        = cnt_q;
      period_d     = period_q;
      sym_valid_d  = sym_valid_q;
      sym_strobe_d = 1'b0;
      sym_out_d    = sym_out_q;
      miss_d       = miss_q;
      lfsr_step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.newLevel) begin
               period_d = period_new;
               cnt_d    = 32'd0;
            end
         end
         RUN: begin
            if (take) begin
               sym_valid_d = 1'b0;
            end
            if (bus.newLevel) begin
               // Restart pacing; a pending symbol keeps waiting under the new period.
               period_d = period_new;
               cnt_d    = 32'd0;
            end else if (terminal) begin
               cnt_d = 32'd0;
               if (miss) begin
                  miss_d = miss_inc;
               end
               if (state_d == OVER) begin
                  sym_valid_d = 1'b0;
               end else begin
                  lfsr_step    = 1'b1;
                  sym_valid_d  = 1'b1;
                  sym_strobe_d = 1'b1;
                  sym_out_d    = lfsr_nxt[SYM_W-1:0];
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         OVER: begin
            sym_valid_d = 1'b0;
         end
         default: begin
            sym_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge Clk100M) begin
      if (Rst) begin
         cnt_q        <= 32'd0;
         period_q     <= MIN_P;
         sym_valid_q  <= 1'b0;
         sym_strobe_q <= 1'b0;
         sym_out_q    <= '0;
         miss_q       <= 4'd0;
      end else begin
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         sym_valid_q  <= sym_valid_d;
         sym_strobe_q <= sym_strobe_d;
         sym_out_q    <= sym_out_d;
         miss_q       <= miss_d;
      end
   end

   assign bus.symValid  = sym_valid_q;
   assign bus.symOut    = sym_out_q;
   assign bus.symStrobe = sym_strobe_q;
   assign bus.missCount = miss_q;
   assign bus.gameOver  = (state_q == OVER);
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sym_generator.sv
// Directed bench for sym_generator with a short minimum period.
module tb_sym_generator;
   import sym_generator_pkg::*;

   localparam int SYM_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;
   int n;

   // Low two bits of the LFSR after 1, 2, 3, ... steps from seed 16'hACE1.
   logic [SYM_W-1:0] sym_tab [26] = '{
      2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1,
      2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2,
      2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2
   };
   logic [SYM_W-1:0] exp_q [$];

   sym_generator_if #(.SYM_W(SYM_W)) bus ();

   sym_generator #(
      .SYM_W      (SYM_W),
      .LFSR_SEED  (16'hACE1),
      .MAX_MISSES (3),
      .MIN_PERIOD (4)
   ) dut (
      .Clk100M (clk),
      .Rst     (rst),
      .bus     (bus)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_reset();
      exp_q.delete();
      foreach (sym_tab[i]) exp_q.push_back(sym_tab[i]);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.newLevel  = 1'b0;
      bus.symGenMax = 32'd0;
      bus.symTaken  = 1'b0;
      step();
      step();
      rst = 1'b0;
      sb_reset();
   endtask

   task automatic pulse_new_level(input logic [31:0] v);
      bus.newLevel  = 1'b1;
      bus.symGenMax = v;
      step();
      bus.newLevel  = 1'b0;
   endtask

   task automatic check_sym(input string tag);
      if (exp_q.size() == 0) check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
      else check(tag, bus.symOut, exp_q.pop_front());
   endtask

   // Step until a strobe is seen (or the budget runs out); n = steps taken.
   task automatic wait_strobe(input int max_steps, output int steps);
      steps = 0;
      while (steps < max_steps) begin
         step();
         steps++;
         if (bus.symStrobe) break;
      end
      if (!bus.symStrobe) check("strobe_timeout", bus.symStrobe, 1);
      else check_sym("sym");
   endtask

   initial begin
      // Reset state.
      do_reset();
      check("rst_valid",  bus.symValid, 0);
      check("rst_out",    bus.symOut, 0);
      check("rst_strobe", bus.symStrobe, 0);
      check("rst_miss",   bus.missCount, 0);
      check("rst_over",   bus.gameOver, 0);
      check("rst_state",  32'(bus.state_dbg), 32'(IDLE));

      // IDLE ignores symTaken.
      bus.symTaken = 1'b1;
      step();
      step();
      bus.symTaken = 1'b0;
      check("idle_valid", bus.symValid, 0);
      check("idle_state", 32'(bus.state_dbg), 32'(IDLE));

      // Period 8: first strobe 8 cycles after newLevel, then every 8.
      pulse_new_level(32'd8);
      check("run_state", 32'(bus.state_dbg), 32'(RUN));
      wait_strobe(20, n);
      check("p8_first_lat", n, 8);
      check("p8_valid", bus.symValid, 1);
      step();
      check("p8_strobe_one_cycle", bus.symStrobe, 0);
      check("p8_valid_held", bus.symValid, 1);
      wait_strobe(20, n);
      check("p8_gap", n, 7);
      check("p8_miss1", bus.missCount, 1);
      bus.symTaken = 1'b1;
      step();
      bus.symTaken = 1'b0;
      check("p8_take_drop", bus.symValid, 0);
      wait_strobe(20, n);
      check("p8_gap_after_take", n, 7);
      check("p8_miss_kept", bus.missCount, 1);

      // Clamping of period 0 and 2 to MIN_PERIOD.
      do_reset();
      pulse_new_level(32'd0);
      wait_strobe(20, n);
      check("clamp0_lat", n, 4);
      do_reset();
      pulse_new_level(32'd2);
      wait_strobe(20, n);
      check("clamp2_lat", n, 4);

      // Take every symbol two cycles after its strobe for ten symbols.
      for (int i = 0; i < 10; i++) begin
         step();
         step();
         bus.symTaken = 1'b1;
         check("take_pre_valid", bus.symValid, 1);
         step();
         bus.symTaken = 1'b0;
         check("take_valid_drop", bus.symValid, 0);
         check("take_out_held", bus.symOut, sym_tab[i]);
         wait_strobe(10, n);
         check("take_gap", n, 1);
      end
      check("take_no_miss", bus.missCount, 0);

      // Never take: misses accumulate until game over at cycle 32.
      do_reset();
      pulse_new_level(32'd8);
      wait_strobe(20, n);
      check("miss_lat", n, 8);
      check("miss_cnt0", bus.missCount, 0);
      wait_strobe(20, n);
      check("miss_gap1", n, 8);
      check("miss_cnt1", bus.missCount, 1);
      wait_strobe(20, n);
      check("miss_gap2", n, 8);
      check("miss_cnt2", bus.missCount, 2);
      repeat (7) step();
      check("over_not_yet", bus.gameOver, 0);
      step();
      check("over_flag",   bus.gameOver, 1);
      check("over_valid",  bus.symValid, 0);
      check("over_strobe", bus.symStrobe, 0);
      check("over_miss",   bus.missCount, 3);
      check("over_state",  32'(bus.state_dbg), 32'(OVER));
      pulse_new_level(32'd4);
      bus.symTaken = 1'b1;
      repeat (20) step();
      bus.symTaken = 1'b0;
      check("over_sticky",       bus.gameOver, 1);
      check("over_sticky_valid", bus.symValid, 0);
      check("over_sticky_miss",  bus.missCount, 3);
      rst = 1'b1;
      step();
      check("over_rst_flag", bus.gameOver, 0);
      check("over_rst_miss", bus.missCount, 0);
      check("over_rst_state", 32'(bus.state_dbg), 32'(IDLE));
      rst = 1'b0;

      // Take on the terminal cycle wins: no miss, next symbol strobed.
      do_reset();
      pulse_new_level(32'd4);
      wait_strobe(20, n);
      check("tt_lat", n, 4);
      repeat (3) step();
      bus.symTaken = 1'b1;
      check("tt_pre_valid", bus.symValid, 1);
      step();
      bus.symTaken = 1'b0;
      check("tt_strobe", bus.symStrobe, 1);
      check("tt_valid",  bus.symValid, 1);
      check("tt_miss",   bus.missCount, 0);
      check_sym("tt_sym");

      // Relatch at counter 5 with a symbol pending.
      do_reset();
      pulse_new_level(32'd8);
      wait_strobe(20, n);
      check("rl_lat", n, 8);
      repeat (5) step();
      pulse_new_level(32'd16);
      check("rl_pending_valid", bus.symValid, 1);
      check("rl_pending_miss",  bus.missCount, 0);
      wait_strobe(40, n);
      check("rl_gap", n, 16);
      check("rl_miss", bus.missCount, 1);

      // Reset in RUN with a symbol pending.
      check("mr_pre_valid", bus.symValid, 1);
      rst = 1'b1;
      step();
      check("mr_valid",  bus.symValid, 0);
      check("mr_out",    bus.symOut, 0);
      check("mr_strobe", bus.symStrobe, 0);
      check("mr_miss",   bus.missCount, 0);
      check("mr_state",  32'(bus.state_dbg), 32'(IDLE));
      rst = 1'b0;
      sb_reset();
      repeat (12) step();
      check("mr_idle_valid", bus.symValid, 0);
      check("mr_idle_state", 32'(bus.state_dbg), 32'(IDLE));
      pulse_new_level(32'd4);
      wait_strobe(20, n);
      check("mr_restart_lat", n, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
